// File: rtl/audio_level_meter_pkg.sv
// audio_pkg: shared types and constants for the audio level meter.
//   sample_t            - signed sample word at the default width
//   meter_state_t       - meter FSM states
//   DEFAULT_CLIP_THRESH - default absolute level that flags clipping
package audio_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 24;
  localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_CLIP_THRESH = 24'h7F0000;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PUBLISH
  } meter_state_t;

endpackage

// File: rtl/audio_level_meter_abs_sat.sv
// abs_sat: combinational saturating absolute value with clip detect.
//   x    - two's complement sample
//   mag  - |x|, the most negative code saturates to the largest positive code
//   clip - saturation occurred or mag >= CLIP_THRESH
module abs_sat
  import audio_pkg::*;
#(
  parameter int unsigned             DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]   CLIP_THRESH = DEFAULT_CLIP_THRESH
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] mag,
  output logic                  clip
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic sat;

  always_comb begin
    mag = x;
    sat = 1'b0;
    if (x == MOST_NEG) begin
      mag = MOST_POS;
      sat = 1'b1;
    end else if (x[DATA_WIDTH-1]) begin
      mag = '0 - x;
    end
    clip = sat | (mag >= CLIP_THRESH);
  end

endmodule

// File: rtl/audio_level_meter.sv
// audio_level_meter: per-window peak and mean-absolute level of one I2S channel.
//   sysclk, reset          - single clock, synchronous active-high reset
//   enable                 - metering enable; low discards the current window
//   sample_in, lr_in       - parallel word from the I2S receiver and its channel
//   sample_strobe          - rising edge marks sample_in valid
//   level_peak/level_mean  - max |x| and floor(sum |x| / 2^WINDOW_LOG2)
//   level_valid/level_ready- result handshake
//   clip, overrun          - sticky flags, cleared only by reset
module audio_level_meter
  import audio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned           WINDOW_LOG2 = 8,
  parameter bit                    CHANNEL     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLIP_THRESH = DEFAULT_CLIP_THRESH
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [31:0]           sample_in,
  input  logic                  sample_strobe,
  input  logic                  lr_in,
  output logic [DATA_WIDTH-1:0] level_peak,
  output logic [DATA_WIDTH-1:0] level_mean,
  output logic                  level_valid,
  input  logic                  level_ready,
  output logic                  clip,
  output logic                  overrun
);

  localparam int unsigned ACC_WIDTH = DATA_WIDTH + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] WINDOW = {1'b1, {WINDOW_LOG2{1'b0}}};

  meter_state_t          state;
  logic                  strobe_q;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_mag;
  logic [ACC_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0] peak;
  logic [WINDOW_LOG2:0]  count;

  logic                  accept;
  logic [DATA_WIDTH-1:0] abs_mag;
  logic                  abs_clip;
  logic                  absorb;
  logic [ACC_WIDTH-1:0]  acc_sum;
  logic [DATA_WIDTH-1:0] peak_max;
  logic [WINDOW_LOG2:0]  count_inc;
  logic                  window_done;

  // Only the low DATA_WIDTH bits of the receiver word carry the sample.
  logic unused_hi;
  assign unused_hi = ^sample_in[31:DATA_WIDTH];

  assign accept = sample_strobe & ~strobe_q & enable & (lr_in == CHANNEL);

  abs_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLIP_THRESH(CLIP_THRESH)
  ) u_abs_sat (
    .x   (s1_data),
    .mag (abs_mag),
    .clip(abs_clip)
  );

  // S3 next-state values; the final sample of a window is folded in
  // before publishing so the published result includes it.
  always_comb begin
    absorb      = s2_valid && (state != IDLE);
    acc_sum     = acc + {{WINDOW_LOG2{1'b0}}, s2_mag};
    peak_max    = (s2_mag > peak) ? s2_mag : peak;
    count_inc   = count + 1'b1;
    window_done = absorb && (count_inc == WINDOW);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      strobe_q    <= 1'b0;
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s2_valid    <= 1'b0;
      s2_mag      <= '0;
      acc         <= '0;
      peak        <= '0;
      count       <= '0;
      level_peak  <= '0;
      level_mean  <= '0;
      level_valid <= 1'b0;
      clip        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      strobe_q <= sample_strobe;

      if (level_valid && level_ready)
        level_valid <= 1'b0;

      if (!enable) begin
        state    <= IDLE;
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        acc      <= '0;
        peak     <= '0;
        count    <= '0;
      end else begin
        s1_valid <= accept;
        if (accept)
          s1_data <= sample_in[DATA_WIDTH-1:0];

        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_mag <= abs_mag;
          if (abs_clip)
            clip <= 1'b1;
        end

        // Publishing clears the window in the same edge, so the next
        // window starts immediately and no pipelined sample is lost.
        if (window_done) begin
          state       <= PUBLISH;
          level_peak  <= peak_max;
          level_mean  <= acc_sum[ACC_WIDTH-1 -: DATA_WIDTH];
          level_valid <= 1'b1;
          if (level_valid && !level_ready)
            overrun <= 1'b1;
          acc   <= '0;
          peak  <= '0;
          count <= '0;
        end else begin
          state <= ACCUM;
          if (absorb) begin
            acc   <= acc_sum;
            peak  <= peak_max;
            count <= count_inc;
          end
        end
      end
    end
  end

endmodule
